// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states,
// bus request codes, access size and grant vector values.
package ysyx_22040759_mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // Which requester owned the bus most recently (round-robin memory)
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // Bus request direction
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // Double-word access size, used for every instruction fetch
    localparam logic [2:0] SIZE_DW = 3'b011;

    // Grant vector values
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Two-requester memory arbiter in front of a single bus bridge.
// Handshake: a requester holds x_valid until it is accepted; acceptance
// happens on a clock edge in IDLE, after which the request fields are
// latched and the requester inputs are ignored. The bridge sees b_valid
// with stable fields for the whole BUSY state; b_ready is a one-cycle
// completion pulse that is forwarded combinationally as x_ready, with
// x_rdata = b_rdata in that cycle and zero otherwise. One DONE cycle with
// the bus idle separates consecutive transactions. Simultaneous requests
// in IDLE go to the port that did not win last time.
module ysyx_22040759_mem_arbiter
    import ysyx_22040759_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    // instruction port (read only)
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    // data port
    input  logic              d_valid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_size,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    // bus bridge
    output logic              b_valid,
    output logic              b_req,
    output logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_wdata,
    output logic [2:0]        b_size,
    input  logic              b_ready,
    input  logic [DATA_W-1:0] b_rdata,
    // current owner
    output logic [1:0]        grant
);

    arb_state_e        state_q, state_d;
    owner_e            last_q, last_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;

    // State and latched request registers, synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= OWNER_I;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
        end
    end

    // Next state: round-robin pick in IDLE, latch the winner's request,
    // record the winner immediately so the next tie goes the other way
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        case (state_q)
            IDLE: begin
                if (d_valid && (!i_valid || last_q == OWNER_I)) begin
                    state_d = BUSY_D;
                    last_d  = OWNER_D;
                    req_d   = d_req;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    size_d  = d_size;
                end else if (i_valid) begin
                    state_d = BUSY_I;
                    last_d  = OWNER_I;
                    req_d   = REQ_READ;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    size_d  = SIZE_DW;
                end
            end
            BUSY_I, BUSY_D: begin
                if (b_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: bus request only while busy, completion forwarded same cycle
    always_comb begin
        b_valid = 1'b0;
        b_req   = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        b_size  = '0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        grant   = GRANT_NONE;
        if (state_q == BUSY_I || state_q == BUSY_D) begin
            b_valid = 1'b1;
            b_req   = req_q;
            b_addr  = addr_q;
            b_wdata = wdata_q;
            b_size  = size_q;
        end
        if (state_q == BUSY_I) begin
            grant   = GRANT_I;
            i_ready = b_ready;
            if (b_ready) i_rdata = b_rdata;
        end
        if (state_q == BUSY_D) begin
            grant   = GRANT_D;
            d_ready = b_ready;
            if (b_ready) d_rdata = b_rdata;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the memory arbiter: fetch path, tie-break order,
// continuous-contention alternation, field stability, reset abort and
// requester dropping valid while busy.
module tb_ysyx_22040759_mem_arbiter;
    import ysyx_22040759_mem_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ready;
    logic [63:0] i_rdata;
    logic        d_valid;
    logic        d_req;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        b_valid;
    logic        b_req;
    logic [63:0] b_addr;
    logic [63:0] b_wdata;
    logic [2:0]  b_size;
    logic        b_ready;
    logic [63:0] b_rdata;
    logic [1:0]  grant;

    int pass_cnt  = 0;
    int check_cnt = 0;

    ysyx_22040759_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock   (clock),
        .reset   (reset),
        .i_valid (i_valid),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_size  (d_size),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .b_valid (b_valid),
        .b_req   (b_req),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_size  (b_size),
        .b_ready (b_ready),
        .b_rdata (b_rdata),
        .grant   (grant)
    );

    // clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    logic [63:0] st;
    assign st = {62'd0, dut.state_q};

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_addr  = '0;
        d_valid = 1'b0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_size  = '0;
        b_ready = 1'b0;
        b_rdata = '0;
        step();
        step();
        // reset state
        chk("rst_state",   st, 64'(IDLE));
        chk("rst_b_valid", b_valid, 0);
        chk("rst_grant",   grant, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_b_addr",  b_addr, 0);
        reset = 1'b0;
        step();

        // ---- instruction fetch, bridge answers after 3 cycles ----
        i_valid = 1'b1;
        i_addr  = 64'h8000_0000;
        step();
        i_valid = 1'b0;
        chk("if_state",   st, 64'(BUSY_I));
        chk("if_b_valid", b_valid, 1);
        chk("if_b_req",   b_req, 0);
        chk("if_b_size",  b_size, 3);
        chk("if_b_addr",  b_addr, 64'h8000_0000);
        chk("if_grant",   grant, 2'b01);
        b_rdata = 64'h0000_0013_0000_0093;
        #1;
        chk("if_rdata_idle", i_rdata, 0);
        chk("if_ready_wait", i_ready, 0);
        step();
        step();
        chk("if_b_valid_hold", b_valid, 1);
        b_ready = 1'b1;
        #1;
        chk("if_i_ready", i_ready, 1);
        chk("if_i_rdata", i_rdata, 64'h0000_0013_0000_0093);
        chk("if_d_ready", d_ready, 0);
        step();
        b_ready = 1'b0;
        #1;
        chk("if_done",         st, 64'(DONE));
        chk("if_done_b_valid", b_valid, 0);
        chk("if_done_i_ready", i_ready, 0);
        step();
        chk("if_idle", st, 64'(IDLE));

        // ---- tie right after reset: data first, then instruction ----
        reset = 1'b1;
        step();
        reset   = 1'b0;
        i_valid = 1'b1;
        i_addr  = 64'h200;
        d_valid = 1'b1;
        d_req   = REQ_READ;
        d_addr  = 64'h100;
        d_size  = 3'd3;
        step();
        d_valid = 1'b0;
        chk("tie_grant_d",  grant, 2'b10);
        chk("tie_b_addr_d", b_addr, 64'h100);
        b_ready = 1'b1;
        b_rdata = 64'h1111;
        #1;
        chk("tie_d_ready", d_ready, 1);
        chk("tie_i_ready", i_ready, 0);
        chk("tie_d_rdata", d_rdata, 64'h1111);
        step();
        b_ready = 1'b0;
        step();
        step();
        chk("tie_grant_i",  grant, 2'b01);
        chk("tie_b_addr_i", b_addr, 64'h200);
        b_ready = 1'b1;
        #1;
        chk("tie_i_ready2", i_ready, 1);
        chk("tie_d_rdata0", d_rdata, 0);
        step();
        b_ready = 1'b0;
        i_valid = 1'b0;
        step();

        // ---- continuous contention, six transactions: D,I,D,I,D,I ----
        i_valid = 1'b1;
        d_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_grant", grant, (k % 2 == 0) ? 2'b10 : 2'b01);
            b_ready = 1'b1;
            b_rdata = 64'(k);
            #1;
            chk("rr_i_ready", i_ready, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk("rr_d_ready", d_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            step();
            b_ready = 1'b0;
            step();
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        step();

        // ---- data write, requester fields change while busy ----
        d_valid = 1'b1;
        d_req   = REQ_WRITE;
        d_addr  = 64'h8000_1000;
        d_wdata = 64'hDEAD_BEEF;
        d_size  = 3'd2;
        step();
        d_valid = 1'b0;
        d_req   = REQ_READ;
        d_addr  = 64'h1234_5678;
        d_wdata = 64'h0;
        d_size  = 3'd3;
        #1;
        chk("wr_b_req",   b_req, 1);
        chk("wr_b_addr",  b_addr, 64'h8000_1000);
        chk("wr_b_wdata", b_wdata, 64'hDEAD_BEEF);
        chk("wr_b_size",  b_size, 2);
        step();
        chk("wr_b_addr_hold", b_addr, 64'h8000_1000);
        chk("wr_b_req_hold",  b_req, 1);
        b_ready = 1'b1;
        b_rdata = 64'h55;
        #1;
        chk("wr_d_ready", d_ready, 1);
        chk("wr_d_rdata", d_rdata, 64'h55);
        step();
        b_ready = 1'b0;
        step();

        // ---- reset while BUSY_D before the bridge answers ----
        d_valid = 1'b1;
        d_addr  = 64'h3000;
        step();
        d_valid = 1'b0;
        chk("ra_busy", st, 64'(BUSY_D));
        step();
        reset = 1'b1;
        step();
        b_ready = 1'b1;
        #1;
        chk("ra_state",   st, 64'(IDLE));
        chk("ra_b_valid", b_valid, 0);
        chk("ra_d_ready", d_ready, 0);
        chk("ra_grant",   grant, 0);
        chk("ra_b_addr",  b_addr, 0);
        b_ready = 1'b0;
        reset   = 1'b0;
        step();

        // ---- requester drops valid while BUSY_D ----
        d_valid = 1'b1;
        d_req   = REQ_READ;
        d_addr  = 64'h4000;
        step();
        d_valid = 1'b0;
        step();
        chk("dv_still_busy", b_valid, 1);
        b_ready = 1'b1;
        b_rdata = 64'hABCD;
        #1;
        chk("dv_d_ready", d_ready, 1);
        chk("dv_d_rdata", d_rdata, 64'hABCD);
        step();
        b_ready = 1'b0;
        #1;
        chk("dv_done",    st, 64'(DONE));
        chk("dv_no_pulse", d_ready, 0);
        step();
        step();
        chk("dv_no_regrant_state", st, 64'(IDLE));
        chk("dv_no_regrant_valid", b_valid, 0);
        chk("dv_no_regrant_grant", grant, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
